// File: rtl/soc_system_pio_edge_irq_if.sv
// Avalon-MM slave bus bundle for the edge-capture input PIO.
//   address    : register word address (master -> slave)
//   chipselect : slave select (master -> slave)
//   write_n    : active-low write strobe (master -> slave)
//   writedata  : write data (master -> slave)
//   readdata   : registered read data, latency 1 (slave -> master)
interface soc_system_pio_edge_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_edge_irq.sv
// Parametrised Avalon-MM input PIO with per-bit edge capture, W1C clear,
// interrupt mask, registered IRQ and a saturating event counter.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port  : asynchronous external inputs, WIDTH bits
//   irq      : registered level interrupt
//
// Register map (word address):
//   0 DATA (RO), 1 RISE_EN, 2 FALL_EN, 3 EDGE_CAPTURE (W1C), 4 IRQ_MASK,
//   5 EVENT_COUNT (RO [15:0], any write clears), 6-7 read 0.
//
// Optional feature: define SOC_PIO_DEBOUNCE_EN to insert a per-bit debouncer
// between the synchroniser and edge detection (DEBOUNCE_CYCLES stable cycles).
module soc_system_pio_edge_irq #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    soc_system_pio_edge_irq_if.slave  bus,
    input  logic [WIDTH-1:0]          in_port,
    output logic                      irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] edge_capture_q;
    logic [15:0]      event_count_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic             any_edge;
    logic             wr;
    logic [31:0]      rd_mux;
    logic             irq_q;

    assign wr   = bus.chipselect & ~bus.write_n;
    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef SOC_PIO_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] deb_q;
    logic [CntW-1:0]  deb_cnt_q [WIDTH];

    // A bit only follows sync after it has differed for DEBOUNCE_CYCLES
    // consecutive cycles; any agreeing cycle restarts the count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync[i] != deb_q[i]) begin
                    if (deb_cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                        deb_q[i]     <= sync[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + CntW'(1);
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign stable = deb_q;
`else
    assign stable = sync;
`endif

    always_comb begin
        edge_det = (stable & ~prev_q & rise_en_q) | (~stable & prev_q & fall_en_q);
        any_edge = |edge_det;
        clr      = '0;
        if (wr && bus.address == 3'd3) begin
            clr = bus.writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0:    rd_mux = 32'(stable);
            3'd1:    rd_mux = 32'(rise_en_q);
            3'd2:    rd_mux = 32'(fall_en_q);
            3'd3:    rd_mux = 32'(edge_capture_q);
            3'd4:    rd_mux = 32'(irq_mask_q);
            3'd5:    rd_mux = 32'(event_count_q);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q         <= '0;
            rise_en_q      <= '0;
            fall_en_q      <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            event_count_q  <= '0;
            bus.readdata   <= '0;
            irq_q          <= 1'b0;
        end else begin
            prev_q       <= stable;
            bus.readdata <= rd_mux;
            irq_q        <= |(edge_capture_q & irq_mask_q);

            // New edges win over a same-cycle clear so no event is lost.
            edge_capture_q <= (edge_capture_q & ~clr) | edge_det;

            if (wr && bus.address == 3'd1) rise_en_q  <= bus.writedata[WIDTH-1:0];
            if (wr && bus.address == 3'd2) fall_en_q  <= bus.writedata[WIDTH-1:0];
            if (wr && bus.address == 3'd4) irq_mask_q <= bus.writedata[WIDTH-1:0];

            if (wr && bus.address == 3'd5) begin
                event_count_q <= any_edge ? 16'd1 : 16'd0;
            end else if (any_edge && event_count_q != 16'hFFFF) begin
                event_count_q <= event_count_q + 16'd1;
            end
        end
    end

    assign irq = irq_q;

endmodule

// File: doc/soc_system_pio_edge_irq.md
Name: soc_system_pio_edge_irq

Overview:
Parametrised Avalon-MM input PIO, the next generation of the team's edge-capture input port. Adds:
- configurable width and synchroniser depth
- per-bit rising/falling edge selection
- write-1-to-clear capture
- interrupt mask and registered IRQ
- saturating event counter
- optional per-bit debounce

Sits on the HPS lightweight bridge; the fish-counter sensor lines feed in_port and the IRQ goes to the GIC.

Parameters:
WIDTH, 32, number of input bits (1..32); register bits at or above WIDTH read 0 and ignore writes.
SYNC_STAGES, 2, input synchroniser flops (2..4).
DEBOUNCE_CYCLES, 16, stable cycles required before an input change is accepted (2..65535); used only with the optional feature.

Ports:
clk  in  1  system clock, all logic on its rising edge
reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
address  in  3  register word address
chipselect  in  1  Avalon slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  asynchronous external inputs
irq  out  1  level interrupt, registered

Behaviour:
- Reset (reset_n=0 at a clk edge): readdata, irq, sync chain, prev, edge_capture, rise_en, fall_en, irq_mask and event_count all go to 0. Any operation in progress is abandoned.
- Write strobe: wr = chipselect & ~write_n.
- Register map:
  - 0 DATA (RO): stable input value.
  - 1 RISE_EN (RW): per-bit rising-edge enable.
  - 2 FALL_EN (RW): per-bit falling-edge enable.
  - 3 EDGE_CAPTURE (R/W1C): writing 1 clears the bit, writing 0 has no effect.
  - 4 IRQ_MASK (RW).
  - 5 EVENT_COUNT (RO, bits 15:0; any write clears it).
  - 6-7: read 0, writes ignored.
- Read path: readdata <= mux(address) on every clk edge regardless of chipselect, giving read latency 1. Unused upper bits are 0.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync.
- Stable value: stable = sync (or the debounced value, see Optional Feature). prev <= stable every cycle.
- Edge detection: edge = (stable & ~prev & rise_en) | (~stable & prev & fall_en). Setting both enables for a bit gives any-edge detection.
- Capture update: edge_capture <= (edge_capture & ~clr) | edge, where clr = writedata[WIDTH-1:0] when wr and address==3, else 0.
  - A new edge in the same cycle as a W1C on that bit leaves the bit set; events are never lost.
- Latency: in_port first sampled high at edge N.
  - Capture bit set at edge N+SYNC_STAGES.
  - irq high at edge N+SYNC_STAGES+1.
  - Capture readable in readdata one edge after address=3 is presented.
- IRQ: irq <= |(edge_capture & irq_mask) evaluated on the current register values.
  - Writing a mask while a capture bit is pending asserts irq one cycle later.
  - Clearing the last pending masked bit deasserts irq one cycle after the clearing edge.
- Event counter: event_count increments by 1 in any cycle where |edge is true, regardless of how many bits fired. It saturates at 0xFFFF.
  - A write to address 5 sets the counter to 0.
  - Write to address 5 and an edge in the same cycle: counter goes to 1.
- Mask changes: changing rise_en or fall_en affects detection from the next cycle only. Bits already captured are not cleared.

Optional Feature:
Macro SOC_PIO_DEBOUNCE_EN.
- Defined: each bit has a counter of clog2(DEBOUNCE_CYCLES+1) bits.
  - When sync differs from the debounced value, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, debounced <= sync and the counter resets to 0.
  - Any cycle where sync equals the debounced value resets the counter to 0.
  - stable = debounced. Added latency is DEBOUNCE_CYCLES cycles; glitches shorter than DEBOUNCE_CYCLES cycles are invisible.
  - Debounced values and counters reset to 0.
- Undefined: no counters are instantiated and stable = sync; timing is exactly as in Behaviour.

Test Plan:
1. Reset then all reads: addresses 0-7 return 0x00000000 and irq=0. Assert reset_n=0 mid-capture with a bit set: capture, masks and irq are 0 on the next edge.
2. Rising only: RISE_EN=0x1, in_port[0] 0->1 at edge N.
   - EDGE_CAPTURE=0x1 at edge N+2 and EVENT_COUNT=1.
   - in_port[0] 1->0 gives no new capture.
3. Falling plus any-edge: RISE_EN=0x2, FALL_EN=0x6, toggle bits 1 and 2 high then low.
   - Capture becomes 0x6.
   - Count increments once per detecting cycle; bit 2's rising edge is not detected.
4. W1C race: capture=0x3, write 0x3 to address 3 in the same cycle as a new edge on bit 0. Capture becomes 0x1; a write of 0x0 changes nothing.
5. IRQ masking: capture=0x4, IRQ_MASK=0 keeps irq=0.
   - Write IRQ_MASK=0x4: irq=1 one cycle after the write edge.
   - W1C 0x4: irq=0 one cycle after the clearing edge.
6. Saturation and debounce: drive 0x10005 edge cycles, count reads 0xFFFF; write address 5 during an edge cycle, count reads 1.
   - With SOC_PIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16, a 10-cycle pulse gives no capture.
   - A 16-cycle high level captures with 16 cycles of extra latency.
